// File: rtl/char_buf_pkg.sv
// Shared constants and state encoding for the 16x16 character buffer.
// Optional cursor highlight is enabled by CHAR_BUF_CURSOR_EN.
package char_buf_pkg;

  localparam logic [7:0] CHAR_BS    = 8'h08;
  localparam logic [7:0] CHAR_LF    = 8'h0A;
  localparam logic [7:0] CHAR_FF    = 8'h0C;
  localparam logic [7:0] CHAR_CR    = 8'h0D;
  localparam logic [7:0] CHAR_SPACE = 8'h20;

  localparam int GRID_COLS = 16;
  localparam int GRID_ROWS = 16;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } buf_state_t;

  function automatic logic is_print(logic [7:0] c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction

endpackage

// File: rtl/char_buf_if.sv
// Byte write handshake into the character buffer.
// Byte is accepted when wr_valid && wr_ready.
interface char_buf_if;

  logic [7:0] wr_char;
  logic       wr_valid;
  logic       wr_ready;

  modport master (
    output wr_char,
    output wr_valid,
    input  wr_ready
  );

  modport slave (
    input  wr_char,
    input  wr_valid,
    output wr_ready
  );

endinterface

// File: rtl/font_rom.sv
// 128-code x 16-line procedural test font, registered output.
// Space and the top/bottom line of every cell are blank.
module font_rom (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic [10:0] addr,
  output logic [7:0]  data
);

  logic [6:0] code;
  logic [3:0] line;
  logic [7:0] glyph;

  assign code = addr[10:4];
  assign line = addr[3:0];

  always_comb begin
    glyph = 8'h00;
    if (code != 7'h20 && line != 4'd0 && line != 4'd15)
      glyph = {code, 1'b1} ^ {line, 4'h0};
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) data <= 8'h00;
    else        data <= glyph;
  end

endmodule

// File: rtl/char_text_buffer.sv
// 16x16 character text buffer with control codes and glyph read path.
// Define CHAR_BUF_CURSOR_EN to invert the glyph at the cursor cell.
module char_text_buffer
  import char_buf_pkg::*;
(
  input  logic       pclk,
  input  logic       rst_n,
  char_buf_if.slave  wr,
  input  logic [7:0] char_xy,
  input  logic [3:0] char_line,
  output logic [7:0] char_pixels,
  output logic       busy
);

  buf_state_t state, state_nxt;

  logic [7:0] cursor, cursor_nxt;
  logic [7:0] clr_cnt, clr_nxt;
  logic [7:0] bs_pos;
  logic       acc;
  logic       we;
  logic [7:0] wa;
  logic [6:0] wd;

  logic [6:0] mem [256];
  logic [6:0] code_q;
  logic [3:0] line_q;
  logic [7:0] rom_q;

  assign wr.wr_ready = (state == ST_IDLE);
  assign busy        = (state == ST_CLEAR);
  assign acc         = wr.wr_valid && wr.wr_ready;
  assign bs_pos      = (cursor == 8'h00) ? 8'h00
                                         : cursor - 8'd1;

  always_comb begin
    state_nxt  = state;
    cursor_nxt = cursor;
    clr_nxt    = clr_cnt;
    we         = 1'b0;
    wa         = cursor;
    wd         = CHAR_SPACE[6:0];
    unique case (state)
      ST_CLEAR: begin
        we      = 1'b1;
        wa      = clr_cnt;
        clr_nxt = clr_cnt + 8'd1;
        if (clr_cnt == 8'hFF) state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (acc) begin
          unique case (1'b1)
            is_print(wr.wr_char): begin
              we         = 1'b1;
              wd         = wr.wr_char[6:0];
              cursor_nxt = cursor + 8'd1;
            end
            (wr.wr_char == CHAR_CR):
              cursor_nxt = {cursor[7:4], 4'h0};
            (wr.wr_char == CHAR_LF):
              cursor_nxt = {cursor[7:4] + 4'd1, cursor[3:0]};
            (wr.wr_char == CHAR_BS): begin
              cursor_nxt = bs_pos;
              we         = 1'b1;
              wa         = bs_pos;
            end
            (wr.wr_char == CHAR_FF): begin
              cursor_nxt = 8'h00;
              clr_nxt    = 8'h00;
              state_nxt  = ST_CLEAR;
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) state <= ST_CLEAR;
    else        state <= state_nxt;
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      cursor  <= 8'h00;
      clr_cnt <= 8'h00;
    end else begin
      cursor  <= cursor_nxt;
      clr_cnt <= clr_nxt;
    end
  end

  // Cell RAM: a same-cycle read sees the pre-write code.
  always_ff @(posedge pclk) begin
    if (we) mem[wa] <= wd;
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      code_q <= 7'h00;
      line_q <= 4'h0;
    end else begin
      code_q <= mem[char_xy];
      line_q <= char_line;
    end
  end

  font_rom u_font (
    .pclk  (pclk),
    .rst_n (rst_n),
    .addr  ({code_q, line_q}),
    .data  (rom_q)
  );

`ifdef CHAR_BUF_CURSOR_EN
  logic hit1, hit2;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      hit1 <= 1'b0;
      hit2 <= 1'b0;
    end else begin
      hit1 <= (char_xy == cursor);
      hit2 <= hit1;
    end
  end

  assign char_pixels = rom_q ^ {8{hit2}};
`else
  assign char_pixels = rom_q;
`endif

endmodule

// File: tb/tb_char_text_buffer.sv
// Randomized self-checking bench for char_text_buffer.
// Reference model keeps cells/cursor as plain arrays and integers.
module tb_char_text_buffer;

  logic       pclk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] char_xy;
  logic [3:0] char_line;
  logic [7:0] char_pixels;
  logic       busy;

  char_buf_if wr_if ();

  char_text_buffer dut (
    .pclk        (pclk),
    .rst_n       (rst_n),
    .wr          (wr_if),
    .char_xy     (char_xy),
    .char_line   (char_line),
    .char_pixels (char_pixels),
    .busy        (busy)
  );

  always #5 pclk = ~pclk;

  int checks;
  int failures;
  int m_cell [256];
  int m_cur;
  bit cur_en;

  function automatic logic [7:0] glyph(int code, int line);
    if (code == 32 || line == 0 || line == 15) return 8'h00;
    return 8'((code * 2 + 1) ^ (line * 16));
  endfunction

  function automatic logic [7:0] expect_px(int xy, int line);
    logic [7:0] g;
    g = glyph(m_cell[xy], line);
    if (cur_en && xy == m_cur) g = ~g;
    return g;
  endfunction

  function automatic bit is_ignored(int b);
    if (b >= 32 && b <= 126) return 0;
    if (b == 8 || b == 10 || b == 12 || b == 13) return 0;
    return 1;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 256; i++) m_cell[i] = 32;
    m_cur = 0;
  endtask

  task automatic model_apply(int b);
    if (b == 12) model_clear();
    else if (b >= 32 && b <= 126) begin
      m_cell[m_cur] = b;
      m_cur = (m_cur + 1) % 256;
    end else if (b == 13) m_cur = m_cur - (m_cur % 16);
    else if (b == 10) m_cur = ((m_cur / 16 + 1) % 16) * 16 + m_cur % 16;
    else if (b == 8) begin
      if (m_cur > 0) m_cur = m_cur - 1;
      m_cell[m_cur] = 32;
    end
  endtask

  task automatic send(input int b);
    int guard;
    guard = 0;
    @(negedge pclk);
    while (!wr_if.wr_ready && guard < 2000) begin
      @(negedge pclk);
      guard++;
    end
    checks++;
    if (wr_if.wr_ready !== 1'b1) begin
      failures++;
      $display("FAIL send_ready got=%b exp=1", wr_if.wr_ready);
    end
    wr_if.wr_char  = 8'(b);
    wr_if.wr_valid = 1'b1;
    @(posedge pclk);
    model_apply(b);
    #1 wr_if.wr_valid = 1'b0;
  endtask

  task automatic read_chk(input string name, input int xy, input int line);
    logic [7:0] exp;
    @(negedge pclk);
    char_xy   = 8'(xy);
    char_line = 4'(line);
    exp = expect_px(xy, line);
    @(posedge pclk);
    @(posedge pclk);
    #1;
    checks++;
    if (char_pixels !== exp) begin
      failures++;
      $display("FAIL %s xy=%02h line=%0d got=%02h exp=%02h",
               name, xy, line, char_pixels, exp);
    end
  endtask

  task automatic check_cursor(input string name);
    int c;
    int mk;
    c  = m_cur;
    mk = (m_cell[c] == 126) ? 125 : 126;
    send(mk);
    read_chk(name, c, 7);
  endtask

  task automatic set_cursor(input int t);
    int rows;
    send(13);
    rows = ((t / 16) - (m_cur / 16) + 16) % 16;
    repeat (rows) send(10);
    repeat (t % 16) send(8'h78);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    do begin
      @(posedge pclk);
      #1;
      n++;
    end while (!wr_if.wr_ready && n < 600);
  endtask

  task automatic test_reset();
    int n;
    rst_n          = 1'b0;
    wr_if.wr_valid = 1'b1;
    wr_if.wr_char  = 8'h00;
    repeat (3) @(posedge pclk);
    #1;
    checks += 3;
    if (char_pixels !== 8'h00) begin
      failures++;
      $display("FAIL rst_pixels got=%02h exp=00", char_pixels);
    end
    if (wr_if.wr_ready !== 1'b0) begin
      failures++;
      $display("FAIL rst_ready got=%b exp=0", wr_if.wr_ready);
    end
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL rst_busy got=%b exp=1", busy);
    end
    @(negedge pclk);
    rst_n = 1'b1;
    wait_ready(n);
    wr_if.wr_valid = 1'b0;
    model_clear();
    checks += 2;
    if (n !== 256) begin
      failures++;
      $display("FAIL rst_clear_len got=%0d exp=256", n);
    end
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_busy got=%b exp=0", busy);
    end
  endtask

  task automatic test_clear_all();
    for (int i = 0; i < 256; i++)
      read_chk("clear_cell", i, $urandom_range(1, 14));
  endtask

  task automatic test_write_read();
    send(8'h41);
    read_chk("A_line3", 0, 3);
    check_cursor("cursor_after_A");
  endtask

  task automatic test_wrap();
    set_cursor(8'hFF);
    send(8'h42);
    read_chk("B_at_FF", 8'hFF, 5);
    check_cursor("wrap_to_00");
    set_cursor(8'hF5);
    send(8'h0A);
    check_cursor("lf_F5_to_05");
  endtask

  task automatic test_backspace();
    set_cursor(8'h00);
    send(8'h08);
    read_chk("bs_at_0_cell", 0, 4);
    check_cursor("bs_saturate");
    set_cursor(8'h37);
    send(8'h0D);
    check_cursor("cr_37_to_30");
    send(8'h08);
    read_chk("bs_erase_30", 8'h30, 6);
  endtask

  task automatic test_ignored();
    int b;
    for (int i = 0; i < 8; i++) begin
      do b = $urandom_range(0, 255); while (!is_ignored(b));
      send(b);
    end
    check_cursor("ignored_cursor");
    read_chk("ignored_cell", m_cur, 8);
  endtask

  task automatic test_rbw();
    int c;
    logic [7:0] exp;
    @(negedge pclk);
    c = m_cur;
    exp = expect_px(c, 9);
    wr_if.wr_char  = 8'h5A;
    wr_if.wr_valid = 1'b1;
    char_xy        = 8'(c);
    char_line      = 4'd9;
    @(posedge pclk);
    model_apply(8'h5A);
    #1 wr_if.wr_valid = 1'b0;
    @(posedge pclk);
    #1;
    checks++;
    if (char_pixels !== exp) begin
      failures++;
      $display("FAIL rbw_old got=%02h exp=%02h", char_pixels, exp);
    end
    read_chk("rbw_new", c, 9);
  endtask

  task automatic test_random();
    int r;
    int b;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 70) b = $urandom_range(32, 126);
      else if (r < 78) b = 13;
      else if (r < 86) b = 10;
      else if (r < 93) b = 8;
      else do b = $urandom_range(0, 255); while (!is_ignored(b));
      send(b);
    end
    for (int i = 0; i < 40; i++)
      read_chk("rand_cell", $urandom_range(0, 255), $urandom_range(0, 15));
    read_chk("rand_cur_cell", m_cur, 3);
    check_cursor("rand_cursor");
  endtask

  task automatic test_clear_restart();
    int n;
    @(negedge pclk);
    wr_if.wr_char  = 8'h0C;
    wr_if.wr_valid = 1'b1;
    @(posedge pclk);
    model_apply(12);
    #1 wr_if.wr_valid = 1'b0;
    checks += 2;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL ff_busy got=%b exp=1", busy);
    end
    if (wr_if.wr_ready !== 1'b0) begin
      failures++;
      $display("FAIL ff_ready got=%b exp=0", wr_if.wr_ready);
    end
    wait_ready(n);
    checks++;
    if (n !== 256) begin
      failures++;
      $display("FAIL ff_clear_len got=%0d exp=256", n);
    end
    for (int i = 0; i < 12; i++)
      read_chk("ff_cell", $urandom_range(0, 255), $urandom_range(1, 14));
    check_cursor("ff_cursor");
    repeat (20) send($urandom_range(33, 126));
    @(negedge pclk);
    wr_if.wr_char  = 8'h0C;
    wr_if.wr_valid = 1'b1;
    @(posedge pclk);
    #1 wr_if.wr_valid = 1'b0;
    repeat (99) @(posedge pclk);
    @(posedge pclk);
    #1 rst_n = 1'b0;
    #1;
    model_clear();
    checks += 2;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL midrst_busy got=%b exp=1", busy);
    end
    if (char_pixels !== 8'h00) begin
      failures++;
      $display("FAIL midrst_pixels got=%02h exp=00", char_pixels);
    end
    @(negedge pclk);
    rst_n = 1'b1;
    wait_ready(n);
    checks++;
    if (n !== 256) begin
      failures++;
      $display("FAIL midrst_clear_len got=%0d exp=256", n);
    end
    for (int i = 0; i < 12; i++)
      read_chk("midrst_cell", $urandom_range(0, 255), $urandom_range(1, 14));
  endtask

  task automatic test_cursor_cell();
    set_cursor(8'h12);
    read_chk("cursor_cell_12", 8'h12, 4);
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    wr_if.wr_valid = 1'b0;
    wr_if.wr_char  = 8'h00;
    char_xy        = 8'h00;
    char_line      = 4'h0;
`ifdef CHAR_BUF_CURSOR_EN
    cur_en = 1'b1;
`else
    cur_en = 1'b0;
`endif
    model_clear();
    test_reset();
    test_clear_all();
    test_write_read();
    test_wrap();
    test_backspace();
    test_ignored();
    test_rbw();
    test_random();
    test_clear_restart();
    test_cursor_cell();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

endmodule
